// File: rtl/frame_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// frame_buffer_scheduler
//
// Triple-buffer role manager between a camera writer and a display reader.
// Three buffers rotate through the roles W (being written), R (being
// displayed) and P (completed frame waiting for the display). Each completed
// write hands its buffer to P, and each display frame start claims P when a
// fresh frame is available. Frames overwritten in P before display are
// counted as drops. Display frames shown again because nothing new arrived
// are counted as repeats.
//
// Parameters
//   ADDR_WIDTH       width of the buffer base addresses
//   BASE_ADDR        byte address of buffer 0
//   BYTES_PER_PIXEL  bytes per pixel (2 = RGB565)
//
// Ports
//   clk_i               single clock
//   reset_i             asynchronous active-high reset
//   enable_i            scheduler enable; low = synchronous return to reset
//   wr_frame_start_i    pulse: camera begins writing a frame
//   wr_frame_done_i     pulse: last pixel of the frame written
//   rd_frame_start_i    pulse: display begins a frame
//   resolution_width_i  active pixels per line
//   resolution_depth_i  lines per frame
//   wr_buf_o, rd_buf_o  current W / R buffer index (0..2)
//   wr_base_addr_o      registered byte address of W (one cycle behind index)
//   rd_base_addr_o      registered byte address of R (one cycle behind index)
//   rd_valid_o          R holds a completed frame
//   drop_cnt_o          saturating count of frames overwritten in P
//   repeat_cnt_o        saturating count of repeated display frames
// -----------------------------------------------------------------------------
module frame_buffer_scheduler #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(32'h0000_0000),
  parameter int unsigned           BYTES_PER_PIXEL = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  wr_frame_start_i,
  input  logic                  wr_frame_done_i,
  input  logic                  rd_frame_start_i,
  input  logic [15:0]           resolution_width_i,
  input  logic [15:0]           resolution_depth_i,
  output logic [1:0]            wr_buf_o,
  output logic [1:0]            rd_buf_o,
  output logic [ADDR_WIDTH-1:0] wr_base_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_base_addr_o,
  output logic                  rd_valid_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           repeat_cnt_o
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              w_q, w_d;
  logic [1:0]              r_q, r_d;
  logic [1:0]              p_q, p_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    writing_q, writing_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic [15:0]             repeat_cnt_q, repeat_cnt_d;
  logic [ADDR_WIDTH-1:0]   frame_bytes_q, frame_bytes_d;
  logic [ADDR_WIDTH-1:0]   wr_base_q, wr_base_d;
  logic [ADDR_WIDTH-1:0]   rd_base_q, rd_base_d;

  logic [31:0]             pix_count;
  logic [63:0]             frame_bytes_full;
  logic [ADDR_WIDTH-1:0]   frame_bytes_calc;
  logic                    done_eff;

  // Offset of a buffer from BASE_ADDR: index*frame_bytes as a 3-way select
  // of 0, frame_bytes or frame_bytes<<1. Arithmetic wraps at ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] buf_offset(
    input logic [1:0]            idx,
    input logic [ADDR_WIDTH-1:0] fb
  );
    logic [ADDR_WIDTH-1:0] off;
    case (idx)
      2'd1:    off = fb;
      2'd2:    off = fb << 1;
      default: off = '0;
    endcase
    return off;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    pix_count        = 32'(resolution_width_i) * 32'(resolution_depth_i);
    frame_bytes_full = 64'(pix_count) * 64'(BYTES_PER_PIXEL);
    frame_bytes_calc = ADDR_WIDTH'(frame_bytes_full);
  end

  // A done pulse only counts when a frame is actually being written.
  assign done_eff = wr_frame_done_i && writing_q;

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    r_d           = r_q;
    p_d           = p_q;
    pend_valid_d  = pend_valid_q;
    writing_d     = writing_q;
    rd_valid_d    = rd_valid_q;
    drop_cnt_d    = drop_cnt_q;
    repeat_cnt_d  = repeat_cnt_q;
    frame_bytes_d = frame_bytes_q;
    wr_base_d     = BASE_ADDR + buf_offset(w_q, frame_bytes_q);
    rd_base_d     = BASE_ADDR + buf_offset(r_q, frame_bytes_q);

    if (!enable_i) begin
      state_d       = ST_IDLE;
      w_d           = 2'd0;
      r_d           = 2'd1;
      p_d           = 2'd2;
      pend_valid_d  = 1'b0;
      writing_d     = 1'b0;
      rd_valid_d    = 1'b0;
      drop_cnt_d    = '0;
      repeat_cnt_d  = '0;
      frame_bytes_d = frame_bytes_calc;
      wr_base_d     = BASE_ADDR;
      rd_base_d     = BASE_ADDR;
    end else begin
      if (state_q == ST_IDLE) begin
        frame_bytes_d = frame_bytes_calc;
      end

      if (done_eff && rd_frame_start_i) begin
        // Completed frame goes straight to the display; the old display
        // buffer becomes the next write target and P is left alone.
        r_d          = w_q;
        w_d          = r_q;
        pend_valid_d = 1'b0;
        writing_d    = 1'b0;
        rd_valid_d   = 1'b1;
        state_d      = ST_RUN;
        if (pend_valid_q) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
      end else if (done_eff) begin
        w_d          = p_q;
        p_d          = w_q;
        pend_valid_d = 1'b1;
        writing_d    = 1'b0;
        if (pend_valid_q) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end
      end else if (rd_frame_start_i) begin
        if (pend_valid_q) begin
          r_d          = p_q;
          p_d          = r_q;
          pend_valid_d = 1'b0;
          rd_valid_d   = 1'b1;
          state_d      = ST_RUN;
        end else if (state_q == ST_RUN) begin
          repeat_cnt_d = sat_inc(repeat_cnt_q);
        end
      end

      // A start in the same cycle as a done begins the next frame; a start
      // while already writing just restarts the current W buffer.
      if (wr_frame_start_i) begin
        writing_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      w_q           <= 2'd0;
      r_q           <= 2'd1;
      p_q           <= 2'd2;
      pend_valid_q  <= 1'b0;
      writing_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      drop_cnt_q    <= '0;
      repeat_cnt_q  <= '0;
      frame_bytes_q <= '0;
      wr_base_q     <= BASE_ADDR;
      rd_base_q     <= BASE_ADDR;
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      r_q           <= r_d;
      p_q           <= p_d;
      pend_valid_q  <= pend_valid_d;
      writing_q     <= writing_d;
      rd_valid_q    <= rd_valid_d;
      drop_cnt_q    <= drop_cnt_d;
      repeat_cnt_q  <= repeat_cnt_d;
      frame_bytes_q <= frame_bytes_d;
      wr_base_q     <= wr_base_d;
      rd_base_q     <= rd_base_d;
    end
  end

  assign wr_buf_o       = w_q;
  assign rd_buf_o       = r_q;
  assign wr_base_addr_o = wr_base_q;
  assign rd_base_addr_o = rd_base_q;
  assign rd_valid_o     = rd_valid_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign repeat_cnt_o   = repeat_cnt_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_scheduler
//
// Directed bench for frame_buffer_scheduler with default parameters
// (ADDR_WIDTH=32, BASE_ADDR=0, BYTES_PER_PIXEL=2). Inputs change 1 time unit
// after a rising edge; outputs are sampled 1 time unit after the edge that
// consumed the stimulus. Expected values are hand-derived from the role
// permutation (W,R,P) tracked in the comments.
// -----------------------------------------------------------------------------
module tb_frame_buffer_scheduler;

  logic        clk;
  logic        reset_i;
  logic        enable_i;
  logic        wr_frame_start_i;
  logic        wr_frame_done_i;
  logic        rd_frame_start_i;
  logic [15:0] resolution_width_i;
  logic [15:0] resolution_depth_i;
  logic [1:0]  wr_buf_o;
  logic [1:0]  rd_buf_o;
  logic [31:0] wr_base_addr_o;
  logic [31:0] rd_base_addr_o;
  logic        rd_valid_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] repeat_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  frame_buffer_scheduler #(
    .ADDR_WIDTH      (32),
    .BASE_ADDR       (32'h0000_0000),
    .BYTES_PER_PIXEL (2)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .enable_i           (enable_i),
    .wr_frame_start_i   (wr_frame_start_i),
    .wr_frame_done_i    (wr_frame_done_i),
    .rd_frame_start_i   (rd_frame_start_i),
    .resolution_width_i (resolution_width_i),
    .resolution_depth_i (resolution_depth_i),
    .wr_buf_o           (wr_buf_o),
    .rd_buf_o           (rd_buf_o),
    .wr_base_addr_o     (wr_base_addr_o),
    .rd_base_addr_o     (rd_base_addr_o),
    .rd_valid_o         (rd_valid_o),
    .drop_cnt_o         (drop_cnt_o),
    .repeat_cnt_o       (repeat_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    wr_frame_start_i = 1'b1; tick(); wr_frame_start_i = 1'b0;
  endtask

  task automatic pulse_done();
    wr_frame_done_i = 1'b1; tick(); wr_frame_done_i = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_frame_start_i = 1'b1; tick(); rd_frame_start_i = 1'b0;
  endtask

  initial begin
    reset_i            = 1'b1;
    enable_i           = 1'b1;
    wr_frame_start_i   = 1'b0;
    wr_frame_done_i    = 1'b0;
    rd_frame_start_i   = 1'b0;
    resolution_width_i = 16'd640;
    resolution_depth_i = 16'd480;
    #3;
    check("rst_wr_buf",   wr_buf_o, 0);
    check("rst_rd_buf",   rd_buf_o, 1);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_drop",     drop_cnt_o, 0);
    check("rst_repeat",   repeat_cnt_o, 0);
    check("rst_wr_base",  wr_base_addr_o, 0);
    check("rst_rd_base",  rd_base_addr_o, 0);
    tick(); tick();
    reset_i = 1'b0;
    tick(); tick();

    // Address check: frame_bytes = 640*480*2 = 614400. W0 R1 P2.
    pulse_start();
    pulse_done();              // W2 R1 P0 pend=1
    pulse_rd();                // W2 R0 P1 pend=0
    check("addr_wr_buf",   wr_buf_o, 2);
    check("addr_rd_buf",   rd_buf_o, 0);
    check("addr_rd_valid", rd_valid_o, 1);
    tick();
    check("addr_rd_base",  rd_base_addr_o, 0);
    check("addr_wr_base",  wr_base_addr_o, 1228800);

    // Drop check: two frames, no display start in between.
    pulse_start(); pulse_done();   // W1 R0 P2 pend=1
    pulse_start(); pulse_done();   // W2 R0 P1 drop=1
    check("drop_cnt_pre_rd", drop_cnt_o, 1);
    pulse_rd();                    // W2 R1 P0
    check("drop_cnt",    drop_cnt_o, 1);
    check("drop_rd_buf", rd_buf_o, 1);
    check("drop_repeat", repeat_cnt_o, 0);
    check("drop_wr_buf", wr_buf_o, 2);

    // Repeat check: one frame, three display starts.
    pulse_start(); pulse_done();   // W0 R1 P2 pend=1
    pulse_rd();                    // W0 R2 P1
    check("rep_first_rd_buf", rd_buf_o, 2);
    pulse_rd();
    pulse_rd();
    check("rep_rd_buf", rd_buf_o, 2);
    check("rep_cnt",    repeat_cnt_o, 2);
    check("rep_wr_buf", wr_buf_o, 0);

    // Simultaneous done + display start with pend_valid=1.
    pulse_start(); pulse_done();   // W1 R2 P0 pend=1
    pulse_start();
    wr_frame_done_i = 1'b1; rd_frame_start_i = 1'b1;
    tick();
    wr_frame_done_i = 1'b0; rd_frame_start_i = 1'b0;   // W2 R1 P0 drop=2
    check("sim_rd_buf",   rd_buf_o, 1);
    check("sim_wr_buf",   wr_buf_o, 2);
    check("sim_drop",     drop_cnt_o, 2);
    check("sim_rd_valid", rd_valid_o, 1);

    // A done without a preceding start is ignored.
    pulse_done();
    check("idle_done_wr_buf", wr_buf_o, 2);
    check("idle_done_drop",   drop_cnt_o, 2);
    tick();
    check("sim_wr_base", wr_base_addr_o, 1228800);
    check("sim_rd_base", rd_base_addr_o, 614400);

    // Resolution frozen in RUN.
    resolution_width_i = 16'd320;
    tick(); tick(); tick();
    check("freeze_wr_base", wr_base_addr_o, 1228800);
    check("freeze_rd_base", rd_base_addr_o, 614400);

    // One-cycle soft reset via enable_i.
    enable_i = 1'b0;
    tick();
    enable_i = 1'b1;
    check("soft_wr_buf",   wr_buf_o, 0);
    check("soft_rd_buf",   rd_buf_o, 1);
    check("soft_rd_valid", rd_valid_o, 0);
    check("soft_drop",     drop_cnt_o, 0);
    check("soft_repeat",   repeat_cnt_o, 0);
    check("soft_rd_base",  rd_base_addr_o, 0);
    tick();
    check("soft_new_rd_base", rd_base_addr_o, 307200);
    check("soft_new_wr_base", wr_base_addr_o, 0);

    // In IDLE a display start with nothing pending is not a repeat.
    pulse_rd();
    check("idle_repeat", repeat_cnt_o, 0);
    check("idle_rd_buf", rd_buf_o, 1);

    // Reset mid-frame. Build non-reset state first: W2 R0.
    pulse_start(); pulse_done(); pulse_rd();
    check("pre_rst_wr_buf", wr_buf_o, 2);
    pulse_start();
    reset_i = 1'b1;
    #2;
    check("async_wr_buf",   wr_buf_o, 0);
    check("async_rd_buf",   rd_buf_o, 1);
    check("async_rd_valid", rd_valid_o, 0);
    tick();
    reset_i = 1'b0;
    tick();
    pulse_done();
    check("post_rst_done_wr_buf", wr_buf_o, 0);
    pulse_rd();
    check("post_rst_rd_buf",   rd_buf_o, 1);
    check("post_rst_rd_valid", rd_valid_o, 0);
    check("post_rst_repeat",   repeat_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
